// File: rtl/pinfilter_pkg.sv
// Shared constants and helpers for the multi-channel pin filter.
package pinfilter_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_STABLE_CNT  = 2;

  // Width of a counter able to hold 0..stable_cnt, never narrower than one bit.
  function automatic int cnt_width(input int stable_cnt);
    int w;
    w = $clog2(stable_cnt + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pinfilter_chan.sv
// One filter channel: synchroniser, debounce counter, filtered level and edge pulses.
module pinfilter_chan
  import pinfilter_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   STABLE_CNT  = DEF_STABLE_CNT,
  parameter logic INIT_BIT    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic din,
  output logic dout,
  output logic pos_edge,
  output logic neg_edge,
  output logic edge_next
);

  localparam int            CW       = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   dout_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout;
    if (ena) begin
      if (s == dout) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        dout_d = s;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Lets the bank register its any_edge in the same cycle as the edge flags.
  assign edge_next = dout_d ^ dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{INIT_BIT}};
      cnt_q    <= '0;
      dout     <= INIT_BIT;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], din};
      cnt_q    <= cnt_d;
      dout     <= dout_d;
      pos_edge <= dout_d & ~dout;
      neg_edge <= ~dout_d & dout;
    end
  end

endmodule

// File: rtl/pinfilter_bank.sv
// N independent pin filters with a shared registered any-edge indication.
module pinfilter_bank
  import pinfilter_pkg::*;
#(
  parameter int           N           = 8,
  parameter int           SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int           STABLE_CNT  = DEF_STABLE_CNT,
  parameter logic [N-1:0] INIT        = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ena,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic [N-1:0] pos_edge,
  output logic [N-1:0] neg_edge,
  output logic         any_edge
);

  if (N < 1) begin : g_bad_n
    $error("pinfilter_bank: N must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pinfilter_bank: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CNT < 1) begin : g_bad_cnt
    $error("pinfilter_bank: STABLE_CNT must be at least 1");
  end

  logic [N-1:0] edge_next;

  for (genvar i = 0; i < N; i++) begin : g_chan
    pinfilter_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CNT (STABLE_CNT),
      .INIT_BIT   (INIT[i])
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .ena      (ena),
      .din      (din[i]),
      .dout     (dout[i]),
      .pos_edge (pos_edge[i]),
      .neg_edge (neg_edge[i]),
      .edge_next(edge_next[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_edge <= 1'b0;
    end else begin
      any_edge <= |edge_next;
    end
  end

endmodule
